// File: rtl/sram_b_arb_pkg.sv
// Shared constants, pick result type and round-robin search helper for the sram_b port arbiter.
package sram_b_arb_pkg;

    localparam int unsigned SRAM_B_ABITS = 20;
    localparam int unsigned SRAM_B_DBITS = 8;
    localparam int unsigned RR_MAX_N     = 8;
    localparam int unsigned RR_IDX_W     = 3;
    localparam int unsigned RR_SUM_W     = RR_IDX_W + 1;
    localparam int unsigned STAT_W       = 16;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of vec[n-1:0], searching upward from ptr with wrap at n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] vec,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int unsigned         n);
        rr_pick_t            r;
        logic [RR_SUM_W-1:0] s;
        r = '0;
        for (int unsigned k = 0; k < RR_MAX_N; k++) begin
            s = RR_SUM_W'(ptr) + RR_SUM_W'(k);
            if (s >= RR_SUM_W'(n)) begin
                s = s - RR_SUM_W'(n);
            end
            if ((k < n) && !r.found && vec[s[RR_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = s[RR_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or above ptr, with wrap.
module rr_arbiter
    import sram_b_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]        req,
    input  logic [RR_IDX_W-1:0] ptr,
    output logic [N-1:0]        grant_onehot,
    output logic [RR_IDX_W-1:0] grant_idx,
    output logic                any
);

    logic [RR_MAX_N-1:0] w_req_ext;
    rr_pick_t            w_pick;

    assign w_req_ext    = RR_MAX_N'(req);
    assign w_pick       = rr_pick(w_req_ext, ptr, N);
    assign any          = w_pick.found;
    assign grant_idx    = w_pick.idx;
    assign grant_onehot = w_pick.found ? (N'(1) << w_pick.idx) : '0;

endmodule

// File: rtl/sram_b_port_arbiter.sv
// Shares one 1W/1R sram_b between NREQ requesters; writes and reads are arbitrated separately.
// Optional counters enabled by SRAM_B_PORT_ARBITER_STATS_EN.
module sram_b_port_arbiter
    import sram_b_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ABITS = SRAM_B_ABITS,
    parameter int unsigned DBITS = SRAM_B_DBITS
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ*ABITS-1:0]   req_addr,
    input  logic [NREQ*DBITS-1:0]   req_data,
    input  logic [NREQ*DBITS-1:0]   req_wem,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [DBITS-1:0]        rsp_data,
    output logic                    CE0,
    output logic [ABITS-1:0]        A0,
    output logic [DBITS-1:0]        D0,
    output logic                    WE0,
    output logic [DBITS-1:0]        WEM0,
    output logic                    CE1,
    output logic [ABITS-1:0]        A1,
    input  logic [DBITS-1:0]        Q1
`ifdef SRAM_B_PORT_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0]       conflict_cnt,
    output logic [NREQ*STAT_W-1:0]  rd_grant_cnt
`endif
);

    logic [ABITS-1:0]    w_addr [RR_MAX_N];
    logic [DBITS-1:0]    w_data [RR_MAX_N];
    logic [DBITS-1:0]    w_wem  [RR_MAX_N];
    logic [NREQ-1:0]     w_wr_req;
    logic [NREQ-1:0]     w_rd_req;
    logic [NREQ-1:0]     w_wr_oh;
    logic [NREQ-1:0]     w_rd_oh;
    logic [RR_IDX_W-1:0] w_gw;
    logic [RR_IDX_W-1:0] w_gr;
    logic [RR_IDX_W-1:0] w_gw_inc;
    logic [RR_IDX_W-1:0] w_gr_inc;
    logic                w_wr_any;
    logic                w_rd_any;
    logic                w_conflict;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [RR_IDX_W-1:0] r_wr_ptr;
    logic [RR_IDX_W-1:0] r_rd_ptr;
    logic [RR_IDX_W-1:0] r_rsp_owner;
    logic                r_rsp_vld;

    // Unflatten request payloads into power-of-two arrays so a grant index selects them directly.
    for (genvar g = 0; g < RR_MAX_N; g++) begin : g_unpack
        if (g < NREQ) begin : g_used
            assign w_addr[g] = req_addr[g*ABITS +: ABITS];
            assign w_data[g] = req_data[g*DBITS +: DBITS];
            assign w_wem[g]  = req_wem[g*DBITS +: DBITS];
        end else begin : g_pad
            assign w_addr[g] = '0;
            assign w_data[g] = '0;
            assign w_wem[g]  = '0;
        end
    end

    assign w_wr_req = req_valid & req_we;
    assign w_rd_req = req_valid & ~req_we;

    rr_arbiter #(.N(NREQ)) u_wr_arb (
        .req          (w_wr_req),
        .ptr          (r_wr_ptr),
        .grant_onehot (w_wr_oh),
        .grant_idx    (w_gw),
        .any          (w_wr_any)
    );

    rr_arbiter #(.N(NREQ)) u_rd_arb (
        .req          (w_rd_req),
        .ptr          (r_rd_ptr),
        .grant_onehot (w_rd_oh),
        .grant_idx    (w_gr),
        .any          (w_rd_any)
    );

    // Write always wins a same-address collision; the read candidate loses this slot only.
    assign w_conflict = w_wr_any & w_rd_any & (w_addr[w_gw] == w_addr[w_gr]);
    assign w_wr_acc   = ~RST & w_wr_any;
    assign w_rd_acc   = ~RST & w_rd_any & ~w_conflict;

    assign w_gw_inc = (w_gw == RR_IDX_W'(NREQ - 1)) ? '0 : w_gw + RR_IDX_W'(1);
    assign w_gr_inc = (w_gr == RR_IDX_W'(NREQ - 1)) ? '0 : w_gr + RR_IDX_W'(1);

    always_comb begin
        req_ready = '0;
        CE0       = 1'b0;
        WE0       = 1'b0;
        A0        = '0;
        D0        = '0;
        WEM0      = '0;
        CE1       = 1'b0;
        A1        = '0;
        if (w_wr_acc) begin
            req_ready = req_ready | w_wr_oh;
            CE0       = 1'b1;
            WE0       = 1'b1;
            A0        = w_addr[w_gw];
            D0        = w_data[w_gw];
            WEM0      = w_wem[w_gw];
        end
        if (w_rd_acc) begin
            req_ready = req_ready | w_rd_oh;
            CE1       = 1'b1;
            A1        = w_addr[w_gr];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rsp_vld   <= 1'b0;
            r_rsp_owner <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_gw_inc;
            end
            if (w_rd_acc) begin
                r_rd_ptr    <= w_gr_inc;
                r_rsp_owner <= w_gr;
            end
            r_rsp_vld <= w_rd_acc;
        end
    end

    // A reset arriving during the response cycle suppresses the response.
    assign rsp_valid = (r_rsp_vld & ~RST) ? (NREQ'(1) << r_rsp_owner) : '0;
    assign rsp_data  = Q1;

`ifdef SRAM_B_PORT_ARBITER_STATS_EN
    logic [STAT_W-1:0] r_conflict_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + STAT_W'(1);
        end
    end

    assign conflict_cnt = r_conflict_cnt;

    for (genvar g = 0; g < NREQ; g++) begin : g_rd_cnt
        logic [STAT_W-1:0] r_cnt;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_cnt <= '0;
            end else if (w_rd_acc && (w_gr == RR_IDX_W'(g)) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + STAT_W'(1);
            end
        end

        assign rd_grant_cnt[g*STAT_W +: STAT_W] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_sram_b_port_arbiter.sv
// Bench for sram_b_port_arbiter: SRAM stub, behavioural arbitration model, directed and random traffic.
// Counter checks run when SRAM_B_PORT_ARBITER_STATS_EN is defined.
module tb_sram_b_port_arbiter;

    localparam int NREQ  = 4;
    localparam int ABITS = 20;
    localparam int DBITS = 8;

    logic                  CLK;
    logic                  RST;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_we;
    logic [NREQ*ABITS-1:0] req_addr;
    logic [NREQ*DBITS-1:0] req_data;
    logic [NREQ*DBITS-1:0] req_wem;
    logic [NREQ-1:0]       rsp_valid;
    logic [DBITS-1:0]      rsp_data;
    logic                  CE0;
    logic [ABITS-1:0]      A0;
    logic [DBITS-1:0]      D0;
    logic                  WE0;
    logic [DBITS-1:0]      WEM0;
    logic                  CE1;
    logic [ABITS-1:0]      A1;
    logic [DBITS-1:0]      Q1;
`ifdef SRAM_B_PORT_ARBITER_STATS_EN
    logic [15:0]           conflict_cnt;
    logic [NREQ*16-1:0]    rd_grant_cnt;
`endif

    sram_b_port_arbiter #(.NREQ(NREQ), .ABITS(ABITS), .DBITS(DBITS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_wem   (req_wem),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .CE0       (CE0),
        .A0        (A0),
        .D0        (D0),
        .WE0       (WE0),
        .WEM0      (WEM0),
        .CE1       (CE1),
        .A1        (A1),
        .Q1        (Q1)
`ifdef SRAM_B_PORT_ARBITER_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .rd_grant_cnt (rd_grant_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM stub driven only by the DUT pins: 1-cycle read, masked write.
    logic [DBITS-1:0] sram [logic [ABITS-1:0]];
    logic [DBITS-1:0] stub_old;
    always @(posedge CLK) begin
        if (CE1) Q1 <= sram.exists(A1) ? sram[A1] : 8'h00;
        if (CE0 && WE0) begin
            stub_old = sram.exists(A0) ? sram[A0] : 8'h00;
            sram[A0] = (stub_old & ~WEM0) | (D0 & WEM0);
        end
    end

    // Requester-side intent, which is also what the model reasons from.
    logic             p_valid [NREQ];
    logic             p_we    [NREQ];
    logic [ABITS-1:0] p_addr  [NREQ];
    logic [DBITS-1:0] p_data  [NREQ];
    logic [DBITS-1:0] p_wem   [NREQ];

    // Model state.
    logic [DBITS-1:0] ref_mem [logic [ABITS-1:0]];
    int               m_wr_ptr, m_rd_ptr, m_owner, m_conflicts;
    int               m_rd_cnt [NREQ];
    logic [DBITS-1:0] m_rsp_data;
    logic [NREQ-1:0]  m_acc;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ABITS-1:0] pool [8] = '{20'h00000, 20'hFFFFF, 20'h00010, 20'h00011,
                                   20'h00012, 20'h00400, 20'h12345, 20'h80000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [DBITS-1:0] mrd(input logic [ABITS-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive();
        req_valid = {p_valid[3], p_valid[2], p_valid[1], p_valid[0]};
        req_we    = {p_we[3], p_we[2], p_we[1], p_we[0]};
        req_addr  = {p_addr[3], p_addr[2], p_addr[1], p_addr[0]};
        req_data  = {p_data[3], p_data[2], p_data[1], p_data[0]};
        req_wem   = {p_wem[3], p_wem[2], p_wem[1], p_wem[0]};
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic [ABITS-1:0] a,
                           input logic [DBITS-1:0] d, input logic [DBITS-1:0] m);
        p_valid[i] = v; p_we[i] = we; p_addr[i] = a; p_data[i] = d; p_wem[i] = m;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0);
        drive();
    endtask

    // Compare every output against the model, advance the model across the edge, then the clock.
    task automatic cycle();
        logic [NREQ-1:0] wv, rv, exp_rdy, exp_rsp;
        int gw, gr;
        bit conflict, ce1;
        #2;
        for (int i = 0; i < NREQ; i++) begin
            wv[i] = p_valid[i] && p_we[i];
            rv[i] = p_valid[i] && !p_we[i];
        end
        exp_rsp = (!RST && m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (exp_rsp != 0) chk("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
        if (RST) begin
            chk("ready_rst", 32'(req_ready), 0);
            chk("ce0_rst", 32'(CE0), 0);
            chk("we0_rst", 32'(WE0), 0);
            chk("ce1_rst", 32'(CE1), 0);
            m_wr_ptr = 0; m_rd_ptr = 0; m_owner = -1; m_acc = '0; m_conflicts = 0;
            for (int i = 0; i < NREQ; i++) m_rd_cnt[i] = 0;
        end else begin
            gw = pick(wv, m_wr_ptr);
            gr = pick(rv, m_rd_ptr);
            conflict = (gw >= 0) && (gr >= 0) && (p_addr[gw] == p_addr[gr]);
            ce1 = (gr >= 0) && !conflict;
            exp_rdy = '0;
            if (gw >= 0) exp_rdy[gw] = 1'b1;
            if (ce1) exp_rdy[gr] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("ce0", 32'(CE0), 32'(gw >= 0));
            chk("we0", 32'(WE0), 32'(gw >= 0));
            chk("ce1", 32'(CE1), 32'(ce1));
            if (gw >= 0) begin
                chk("a0", 32'(A0), 32'(p_addr[gw]));
                chk("d0", 32'(D0), 32'(p_data[gw]));
                chk("wem0", 32'(WEM0), 32'(p_wem[gw]));
            end else begin
                chk("a0_idle", 32'(A0), 0);
                chk("d0_idle", 32'(D0), 0);
                chk("wem0_idle", 32'(WEM0), 0);
            end
            if (ce1) chk("a1", 32'(A1), 32'(p_addr[gr]));
            m_owner = -1;
            if (ce1) begin
                m_owner    = gr;
                m_rsp_data = mrd(p_addr[gr]);
                m_rd_ptr   = (gr + 1) % NREQ;
                m_rd_cnt[gr]++;
            end
            if (gw >= 0) begin
                ref_mem[p_addr[gw]] = (mrd(p_addr[gw]) & ~p_wem[gw]) | (p_data[gw] & p_wem[gw]);
                m_wr_ptr = (gw + 1) % NREQ;
            end
            if (conflict) m_conflicts++;
            m_acc = exp_rdy;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle_all();
        RST = 1'b1;
        cycle();
        cycle();
        RST = 1'b0;
    endtask

    initial begin
        logic [DBITS-1:0] exp_d;
        RST = 1'b1;
        m_owner = -1; m_wr_ptr = 0; m_rd_ptr = 0; m_conflicts = 0; m_acc = '0;
        for (int i = 0; i < NREQ; i++) m_rd_cnt[i] = 0;
        for (int i = 0; i < NREQ; i++) begin
            sram[20'h10 + ABITS'(i)]    = 8'h30 + 8'(i);
            ref_mem[20'h10 + ABITS'(i)] = 8'h30 + 8'(i);
        end
        sram[20'h20] = 8'h5C;
        ref_mem[20'h20] = 8'h5C;

        // Reset state with live requests present.
        idle_all();
        set_req(0, 1'b1, 1'b1, 20'h00400, 8'h11, 8'hFF);
        set_req(1, 1'b1, 1'b0, 20'h00010, 8'h00, 8'h00);
        drive();
        #1;
        chk("reset_ready", 32'(req_ready), 0);
        chk("reset_ce0", 32'(CE0), 0);
        chk("reset_ce1", 32'(CE1), 0);
        chk("reset_we0", 32'(WE0), 0);
        cycle();
        do_reset();

        // Four continuous readers: grants rotate 0,1,2,3,0 with 1-cycle responses.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 20'h10 + ABITS'(i), 8'h00, 8'h00);
        drive();
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
            if (c > 0) begin
                exp_d = 8'h30 + 8'((c - 1) % 4);
                chk("rr_rsp_valid", 32'(rsp_valid), 32'(1 << ((c - 1) % 4)));
                chk("rr_rsp_data", 32'(rsp_data), 32'(exp_d));
            end
            cycle();
        end
        do_reset();

        // Same-address write/read: write first, read next cycle, sees new data.
        set_req(0, 1'b1, 1'b1, 20'h00400, 8'hA5, 8'hFF);
        set_req(1, 1'b1, 1'b0, 20'h00400, 8'h00, 8'h00);
        drive();
        #1;
        chk("conf_ready", 32'(req_ready), 32'h1);
        chk("conf_ce1", 32'(CE1), 0);
        cycle();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        drive();
        #1;
        chk("conf_ready2", 32'(req_ready), 32'h2);
        cycle();
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        drive();
        #1;
        chk("conf_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("conf_rsp_data", 32'(rsp_data), 32'hA5);
        cycle();
        do_reset();

        // Masked write merges with earlier contents.
        set_req(0, 1'b1, 1'b1, 20'h12345, 8'hFF, 8'hFF);
        drive();
        cycle();
        set_req(0, 1'b1, 1'b1, 20'h12345, 8'h00, 8'h0F);
        drive();
        cycle();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b1, 1'b0, 20'h12345, 8'h00, 8'h00);
        drive();
        cycle();
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        drive();
        #1;
        chk("mask_rsp_data", 32'(rsp_data), 32'hF0);
        cycle();
        do_reset();

        // Different addresses: write and read both accepted in one cycle.
        set_req(2, 1'b1, 1'b1, 20'h00010, 8'h77, 8'hFF);
        set_req(3, 1'b1, 1'b0, 20'h00020, 8'h00, 8'h00);
        drive();
        #1;
        chk("dual_ready", 32'(req_ready), 32'hC);
        cycle();
        idle_all();
        #1;
        chk("dual_rsp_valid", 32'(rsp_valid), 32'h8);
        chk("dual_rsp_data", 32'(rsp_data), 32'h5C);
        set_req(0, 1'b1, 1'b0, 20'h00010, 8'h00, 8'h00);
        drive();
        cycle();
        idle_all();
        #1;
        chk("dual_wr_landed", 32'(rsp_data), 32'h77);
        cycle();
        do_reset();

        // Reset right after an accepted read drops the response and clears the pointers.
        set_req(1, 1'b1, 1'b0, 20'h00011, 8'h00, 8'h00);
        drive();
        #1;
        chk("mid_ready", 32'(req_ready), 32'h2);
        cycle();
        idle_all();
        set_req(2, 1'b1, 1'b0, 20'h00012, 8'h00, 8'h00);
        drive();
        RST = 1'b1;
        #1;
        chk("mid_rsp_valid_rst", 32'(rsp_valid), 0);
        chk("mid_ready_rst", 32'(req_ready), 0);
        cycle();
        RST = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 20'h10 + ABITS'(i), 8'h00, 8'h00);
        drive();
        #1;
        chk("mid_ptr_zero", 32'(req_ready), 32'h1);
        chk("mid_rsp_valid_after", 32'(rsp_valid), 0);
        cycle();
        do_reset();

        // Random traffic with occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_acc[i]) p_valid[i] = 1'b0;
                if (!p_valid[i] && ($urandom_range(0, 99) < 60)) begin
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                            8'($urandom), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom));
                end
            end
            RST = ($urandom_range(0, 299) == 0);
            drive();
            cycle();
        end
        RST = 1'b0;

`ifdef SRAM_B_PORT_ARBITER_STATS_EN
        idle_all();
        cycle();
        for (int i = 0; i < NREQ; i++)
            chk("rd_grant_cnt", 32'(rd_grant_cnt[i*16 +: 16]), 32'(m_rd_cnt[i]));
        do_reset();
        set_req(0, 1'b1, 1'b1, 20'h00400, 8'h01, 8'hFF);
        set_req(1, 1'b1, 1'b0, 20'h00400, 8'h00, 8'h00);
        drive();
        for (int c = 0; c < 3; c++) cycle();
        chk("conflict_cnt_3", 32'(conflict_cnt), 32'd3);
        chk("conflict_cnt_model", 32'(conflict_cnt), 32'(m_conflicts));
        for (int c = 0; c < 70000; c++) @(posedge CLK);
        #1;
        chk("conflict_cnt_sat", 32'(conflict_cnt), 32'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
